operand_skew_feeder: RTL and testbench
======================================

OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 SHALL expose `clk`, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL expose `rst`, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL expose `start`, input, 1 bit: request to stream one operand tile; sampled in IDLE only.
REQ-004 SHALL expose `base`, input, 10 bits: operand buffer address of column 0; latched on start.
REQ-005 SHALL expose `len`, input, 8 bits: number of columns K (0..255); latched on start.
REQ-006 SHALL expose `rd_en`, output, 1 bit: operand buffer read strobe.
REQ-007 SHALL expose `rd_addr`, output, 10 bits: operand buffer read address.
REQ-008 SHALL expose `rd_data`, input, 64 bits: column word, with row i in bits [16i+15:16i]; valid exactly one cycle after the `rd_en` cycle.
REQ-009 SHALL expose `out_data`, output, 64 bits: skewed array feed, with lane i in bits [16i+15:16i].
REQ-010 SHALL expose `out_valid`, output, 1 bit: `out_data` holds a beat.
REQ-011 SHALL expose `out_ready`, input, 1 bit: array accepts a beat; a beat transfers when `out_valid` && `out_ready`.
REQ-012 SHALL expose `busy`, output, 1 bit: a tile is in progress.
REQ-013 SHALL expose `done`, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, FINISH.
- IDLE->RUN on `start` with `len` != 0.
- IDLE->FINISH on `start` with `len` == 0.
- RUN->DRAIN after the last column read is issued.
- DRAIN->FINISH when beat K+2 transfers.
- FINISH->IDLE unconditionally.
REQ-015 SHALL assert `busy` in RUN and DRAIN only; `busy` deasserts in the FINISH cycle.
REQ-016 SHALL pulse `done` high for exactly the FINISH cycle.
REQ-017 SHALL issue column reads in order k = 0..K-1, at address (base+k) mod 1024.
- Wrap from 1023 to 0 is silent.
REQ-018 SHALL emit exactly K+3 beats, t = 0..K+2.
- Lane i of beat t = column (t-i), row i, when 0 <= t-i < K.
- Lane i is 0 otherwise.
REQ-019 SHALL assert `out_valid` for beat 0 two cycles after the cycle in which `start` is sampled, given `out_ready` held high.
REQ-020 SHALL sustain one beat per cycle while `out_ready` is high.
REQ-021 SHALL, while `out_valid` && !`out_ready`, hold `out_data` stable and not advance the beat count.
- Any read already in flight SHALL be captured in an internal skid register.
- No beat is lost or duplicated.
REQ-022 SHALL suppress `rd_en` when the skid register is occupied and `out_ready` is low.
REQ-023 SHALL ignore `start` in RUN, DRAIN and FINISH; `base` and `len` changes during a tile have no effect.
REQ-024 SHALL drive `out_valid` = 0 in IDLE and FINISH.
REQ-025 SHALL never assert `rd_en` in DRAIN, FINISH or IDLE.
REQ-026 SHALL, on `start` and FINISH in the same cycle, ignore the `start`; a new tile needs `start` in IDLE.

Reset
REQ-027 SHALL, while `rst` is low, force:
- state to IDLE;
- `busy`, `done`, `out_valid`, `rd_en` to 0;
- `rd_addr` and `out_data` to 0;
- delay lines, skid register and counters to 0.
REQ-028 SHALL abort a tile on reset mid-operation: no further beats, no `done` pulse, any in-flight read discarded.
REQ-029 SHALL accept `start` on the first rising edge after `rst` deasserts.

Verification
REQ-030 Basic tile: base=0, K=2, buffer[0]=0x0004_0003_0002_0001, buffer[1]=0x0008_0007_0006_0005, `out_ready`=1.
- Response: 5 beats, in order 0x0000_0000_0000_0001, 0x0000_0000_0002_0005, 0x0000_0003_0006_0000, 0x0004_0007_0000_0000, 0x0008_0000_0000_0000.
- `done` pulses one cycle after the last beat.
REQ-031 Zero length: `start` with K=0.
- Response: no `rd_en`, no `out_valid`; `done` pulses exactly once, one cycle later.
REQ-032 Backpressure: K=4, `out_ready` toggles 1,0,0,1,0,1... from beat 1.
- Response: exactly 7 beats, same data as with `out_ready`=1.
- `out_data` stable during every stall; no extra `rd_en`.
REQ-033 Address wrap: base=1022, K=4.
- Response: `rd_addr` sequence 1022, 1023, 0, 1.
REQ-034 Reset mid-tile: K=10, `rst` low after beat 3.
- Response: all outputs 0 immediately; no `done`.
- A tile with K=1 started after release: exactly 4 beats.
REQ-035 Start while busy: second `start` during a K=6 tile.
- Response: ignored; exactly 9 beats and one `done`.

Source files
------------

// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: streams K operand columns from a buffer into a
// 4-lane systolic array, delaying lane i by i beats so that lane i of
// beat t carries row i of column t-i. Emits K+3 beats per tile.
// Beat 0 leaves combinationally from the buffer read data, which meets
// the two-cycle start-to-beat latency. A single skid register catches a
// read that returns while the array is stalling.
module operand_skew_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  base,
  input  logic [7:0]  len,
  output logic        rd_en,
  output logic [9:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int LANES = 4;
  localparam int LW    = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  len_q;
  logic [9:0]  rd_addr_q;
  logic [7:0]  rd_left_q;
  logic [8:0]  beat_q;
  logic        rd_pend_q;
  logic        skid_vld_q;
  logic [63:0] skid_q;

  logic        active;
  logic        col_phase;
  logic        head_avail;
  logic        fire;
  logic        last_beat;
  logic        start_ok;
  logic [63:0] head_col;

  assign active     = (state_q == RUN) || (state_q == DRAIN);
  // Beats 0..K-1 take a fresh column; beats K..K+2 only flush the skew.
  assign col_phase  = beat_q < {1'b0, len_q};
  assign head_avail = col_phase ? (skid_vld_q || rd_pend_q) : 1'b1;
  assign out_valid  = active && head_avail;
  assign fire       = out_valid && out_ready;
  assign last_beat  = beat_q == ({1'b0, len_q} + 9'd2);
  assign start_ok   = (state_q == IDLE) && start;

  // Column feeding the current beat: the skid register holds the oldest
  // column when occupied, otherwise the read returning this cycle.
  assign head_col = !col_phase ? 64'd0 :
                    skid_vld_q ? skid_q :
                    rd_pend_q  ? rd_data : 64'd0;

  // Hold off reads whenever a column is waiting and the array stalls, so
  // the skid register and the in-flight read are never both occupied.
  assign rd_en   = (state_q == RUN) && !((skid_vld_q || rd_pend_q) && !out_ready);
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // State machine with read-issue counters and the beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= 8'd0;
      rd_addr_q <= 10'd0;
      rd_left_q <= 8'd0;
      beat_q    <= 9'd0;
    end else begin
      if (fire) begin
        beat_q <= beat_q + 9'd1;
      end
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            len_q     <= len;
            rd_addr_q <= base;
            rd_left_q <= len;
            beat_q    <= 9'd0;
            if (len != 8'd0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_en) begin
            rd_addr_q <= rd_addr_q + 10'd1;
            rd_left_q <= rd_left_q - 8'd1;
            if (rd_left_q == 8'd1) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fire && last_beat) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Track the in-flight read and park its data when the array stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= 64'd0;
    end else begin
      rd_pend_q <= rd_en;
      if (skid_vld_q) begin
        if (fire) begin
          skid_vld_q <= rd_pend_q;
          skid_q     <= rd_data;
        end
      end else if (rd_pend_q && !fire) begin
        skid_vld_q <= 1'b1;
        skid_q     <= rd_data;
      end
    end
  end

  // Lane 0 is undelayed
  assign out_data[LW-1:0] = head_col[LW-1:0];

  // Lane gi delays its row by gi accepted beats
  for (genvar gi = 1; gi < LANES; gi++) begin : g_lane
    logic [LW-1:0] line_q [gi];

    // Shift on every accepted beat; clear when a tile starts
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j < gi; j++) begin
          line_q[j] <= '0;
        end
      end else if (start_ok) begin
        for (int j = 0; j < gi; j++) begin
          line_q[j] <= '0;
        end
      end else if (fire) begin
        line_q[0] <= head_col[LW*gi +: LW];
        for (int j = 1; j < gi; j++) begin
          line_q[j] <= line_q[j-1];
        end
      end
    end

    assign out_data[LW*gi +: LW] = line_q[gi-1];
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Scoreboard bench for operand_skew_feeder: the driver pushes expected
// beats, a negedge monitor pops and compares every accepted beat.
module tb_operand_skew_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base = '0;
  logic [7:0]  len = '0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data = '0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  operand_skew_feeder dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:1023];
  logic [63:0] exp_q [$];
  logic [9:0]  rd_log [0:4095];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int beats_total = 0, done_total = 0, rd_total = 0, vld_total = 0;
  int last_fire_cyc = -10, done_cyc = -10, first_valid_cyc = -10;
  int tile_seq = 0, mon_seq = 0, start_cyc = 0;
  logic bp_mode = 1'b0;
  int bp_base = 0;

  // Operand buffer: data valid one cycle after the read strobe, junk otherwise
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= rd_en ? mem[rd_addr] : 64'hBAD0_BAD1_BAD2_BAD3;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference: lane i of beat t is row i of column t-i when that column exists
  function automatic logic [63:0] model(int b, int k, int t);
    logic [63:0] r;
    logic [63:0] col;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = t - i;
      if (c >= 0 && c < k) begin
        col = mem[(b + c) % 1024];
        r[16*i +: 16] = col[16*i +: 16];
      end
    end
    return r;
  endfunction

  // Monitor / scoreboard
  initial begin : monitor
    logic        stall_prev;
    logic [63:0] stall_data;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid_held", 64'(out_valid), 64'd1);
          chk("stall_data_held", out_data, stall_data);
        end
        if (out_valid && mon_seq != tile_seq) begin
          mon_seq = tile_seq;
          first_valid_cyc = cyc;
        end
        if (out_valid) vld_total++;
        if (rd_en) begin
          rd_log[rd_total % 4096] = rd_addr;
          rd_total++;
        end
        if (done) begin
          done_total++;
          done_cyc = cyc;
          chk("finish_out_valid", 64'(out_valid), 64'd0);
          chk("finish_busy", 64'(busy), 64'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL extra_beat: got %h required no beat", out_data);
          end else begin
            chk($sformatf("beat_%0d", beats_total), out_data, exp_q.pop_front());
          end
          beats_total++;
          last_fire_cyc = cyc;
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  // Array ready: high, or a 1,0,0,1,0,1,1,0 pattern once beat 0 is accepted
  initial begin : ready_drv
    int idx;
    bit pat [8];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode && beats_total > bp_base) begin
        out_ready = pat[idx % 8];
        idx++;
      end else begin
        out_ready = 1'b1;
        idx = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tile(int b, int k);
    for (int t = 0; t < k + 3; t++) exp_q.push_back(model(b, k, t));
  endtask

  task automatic pulse_start(int b, int k);
    base = 10'(b);
    len = 8'(k);
    start = 1'b1;
    tile_seq++;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    base = 10'($urandom);
    len = 8'($urandom);
  endtask

  task automatic wait_done(int bound);
    int d0;
    bit ok;
    d0 = done_total;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_total > d0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done required done within %0d cycles", bound);
    end
    tick(3);
  endtask

  task automatic check_tile(string nm, int b, int k, int b0, int d0, int r0);
    chk({nm, "_beats"}, 64'(beats_total - b0), 64'(k + 3));
    chk({nm, "_done_count"}, 64'(done_total - d0), 64'd1);
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_reads"}, 64'(rd_total - r0), 64'(k));
    for (int j = 0; j < k; j++) begin
      chk($sformatf("%s_rd_addr_%0d", nm, j), 64'(rd_log[(r0 + j) % 4096]), 64'((b + j) % 1024));
    end
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin : driver
    int b0, d0, r0, v0;
    for (int a = 0; a < 1024; a++) begin
      mem[a] = {16'h3000 | 16'(a), 16'h2000 | 16'(a), 16'h1000 | 16'(a), 16'(a)};
    end
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;

    // Reset state
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);

    // Basic tile, started on the first edge after reset release
    rst = 1'b1;
    b0 = beats_total; d0 = done_total; r0 = rd_total;
    exp_q.push_back(64'h0000_0000_0000_0001);
    exp_q.push_back(64'h0000_0000_0002_0005);
    exp_q.push_back(64'h0000_0003_0006_0000);
    exp_q.push_back(64'h0004_0007_0000_0000);
    exp_q.push_back(64'h0008_0000_0000_0000);
    pulse_start(0, 2);
    wait_done(40);
    check_tile("basic", 0, 2, b0, d0, r0);
    chk("basic_first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd2);
    chk("basic_done_after_last", 64'(done_cyc - last_fire_cyc), 64'd1);

    // Zero-length tile
    b0 = beats_total; d0 = done_total; r0 = rd_total; v0 = vld_total;
    pulse_start(5, 0);
    wait_done(10);
    chk("zero_done_count", 64'(done_total - d0), 64'd1);
    chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    chk("zero_reads", 64'(rd_total - r0), 64'd0);
    chk("zero_valid_cycles", 64'(vld_total - v0), 64'd0);
    chk("zero_beats", 64'(beats_total - b0), 64'd0);

    // Backpressure
    b0 = beats_total; d0 = done_total; r0 = rd_total;
    bp_base = beats_total;
    bp_mode = 1'b1;
    push_tile(300, 4);
    pulse_start(300, 4);
    wait_done(100);
    bp_mode = 1'b0;
    check_tile("bp", 300, 4, b0, d0, r0);

    // Address wrap
    b0 = beats_total; d0 = done_total; r0 = rd_total;
    push_tile(1022, 4);
    pulse_start(1022, 4);
    wait_done(40);
    check_tile("wrap", 1022, 4, b0, d0, r0);

    // Reset mid-tile after beat 3
    b0 = beats_total; d0 = done_total;
    push_tile(50, 10);
    pulse_start(50, 10);
    for (int i = 0; i < 40 && (beats_total - b0) < 4; i++) tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_rd_en", 64'(rd_en), 64'd0);
    chk("abort_rd_addr", 64'(rd_addr), 64'd0);
    chk("abort_out_data", out_data, 64'd0);
    exp_q.delete();
    tick(5);
    chk("abort_beats", 64'(beats_total - b0), 64'd4);
    chk("abort_no_done", 64'(done_total - d0), 64'd0);
    rst = 1'b1;
    b0 = beats_total; d0 = done_total; r0 = rd_total;
    push_tile(700, 1);
    pulse_start(700, 1);
    wait_done(40);
    check_tile("post_rst", 700, 1, b0, d0, r0);
    chk("post_rst_latency", 64'(first_valid_cyc - start_cyc), 64'd2);

    // Start while busy is ignored
    b0 = beats_total; d0 = done_total; r0 = rd_total;
    push_tile(100, 6);
    pulse_start(100, 6);
    tick(2);
    base = 10'd200;
    len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60);
    check_tile("busy_start", 100, 6, b0, d0, r0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
